led_fade_driver: RTL and testbench



---
 rtl/led_fade_driver.sv | 99 +++++++++
 tb/tb_led_fade_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
//==============================================================================
// led_fade_driver
// Per-LED PWM afterglow: a held input is fully on; a released input fades
// linearly to off at DECAY_STEP per prescaler tick.
// Revision: 1.0
//==============================================================================
`default_nettype none

module led_fade_driver #(
    parameter int NUM_LEDS   = 14,
    parameter int BRIGHT_W   = 8,
    parameter int PRESCALE   = 50000,
    parameter int DECAY_STEP = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [NUM_LEDS-1:0] active,
    output logic                busy
);

    localparam int                   PRESC_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [BRIGHT_W-1:0]  C_MAX        = '1;
    localparam logic [BRIGHT_W-1:0]  C_STEP       = BRIGHT_W'(DECAY_STEP);
    localparam logic [PRESC_W-1:0]   C_PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic [NUM_LEDS-1:0] led_q;
    logic [BRIGHT_W-1:0] level_q [NUM_LEDS];
    logic [BRIGHT_W-1:0] level_d [NUM_LEDS];
    logic [BRIGHT_W-1:0] pwm_cnt_q;
    logic [PRESC_W-1:0]  presc_cnt_q;
    logic                tick_q;

    logic [NUM_LEDS-1:0] led_out_q, led_out_d;
    logic [NUM_LEDS-1:0] active_q, active_d;
    logic                busy_q, busy_d;

    always_comb begin
        led_out_d = '0;
        active_d  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            // Priority: blanking, then held input, then decay tick, else hold.
            if (!enable) begin
                level_d[i] = '0;
            end else if (led_q[i]) begin
                level_d[i] = C_MAX;
            end else if (tick_q) begin
                level_d[i] = (level_q[i] > C_STEP) ? (level_q[i] - C_STEP) : '0;
            end else begin
                level_d[i] = level_q[i];
            end
            led_out_d[i] = enable & (led_q[i] | (level_q[i] > pwm_cnt_q));
            active_d[i]  = (level_q[i] != '0);
        end
        busy_d = |active_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q       <= '0;
            pwm_cnt_q   <= '0;
            presc_cnt_q <= '0;
            tick_q      <= 1'b0;
            led_out_q   <= '0;
            active_q    <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            led_q     <= led_in;
            led_out_q <= led_out_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_q[i] <= level_d[i];
            end
            // Counters park at zero while blanked so a re-enable starts a fresh phase.
            if (!enable) begin
                pwm_cnt_q   <= '0;
                presc_cnt_q <= '0;
                tick_q      <= 1'b0;
            end else begin
                pwm_cnt_q   <= pwm_cnt_q + 1'b1;
                tick_q      <= (presc_cnt_q == C_PRESC_LAST);
                presc_cnt_q <= (presc_cnt_q == C_PRESC_LAST) ? '0 : (presc_cnt_q + 1'b1);
            end
        end
    end

    assign led_out = led_out_q;
    assign active  = active_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: two instances (8-bit/step 4 and 6-bit/step 5)
// checked every cycle against a brightness model plus directed literal checks.
`default_nettype none

module tb_led_fade_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [13:0] led_in = 14'h3FFF;

    logic [13:0] led_out4, active4, led_out5, active5;
    logic        busy4, busy5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_fade_driver #(.NUM_LEDS(14), .BRIGHT_W(8), .PRESCALE(P), .DECAY_STEP(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .led_in(led_in),
        .led_out(led_out4), .active(active4), .busy(busy4)
    );

    // 6-bit levels (MAX 63) make level 3 reachable with step 5: 63, 58, ..., 3, 0.
    led_fade_driver #(.NUM_LEDS(14), .BRIGHT_W(6), .PRESCALE(P), .DECAY_STEP(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .led_in(led_in),
        .led_out(led_out5), .active(active5), .busy(busy5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: level = MAX while the sampled input is held, otherwise loses a fixed
    // step at each decay tick; ticks follow edge m (enabled edges since restart)
    // with m a multiple of P; the PWM phase before edge m+1 is m mod 2^W.
    int          maxv [2] = '{255, 63};
    int          stepv[2] = '{4, 5};
    int          pmod [2] = '{256, 64};
    int          mlvl [2][14];
    int          mcnt = 0;
    logic [13:0] mlq = '0;
    logic [13:0] mout[2];
    logic [13:0] mact[2];
    logic        mbusy[2];
    logic        tick_now;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mout[k] = '0; mact[k] = '0; mbusy[k] = 1'b0;
            for (int i = 0; i < 14; i++) mlvl[k][i] = 0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt = 0;
            mlq  = '0;
            for (int k = 0; k < 2; k++) begin
                mout[k] = '0; mact[k] = '0; mbusy[k] = 1'b0;
                for (int i = 0; i < 14; i++) mlvl[k][i] = 0;
            end
        end else begin
            tick_now = (mcnt >= P) && (mcnt % P == 0);
            for (int k = 0; k < 2; k++) begin
                mbusy[k] = 1'b0;
                for (int i = 0; i < 14; i++) begin
                    mact[k][i] = (mlvl[k][i] != 0);
                    if (mlvl[k][i] != 0) mbusy[k] = 1'b1;
                    if (!enable) begin
                        mout[k][i] = 1'b0;
                        mlvl[k][i] = 0;
                    end else begin
                        mout[k][i] = mlq[i] || (mlvl[k][i] > (mcnt % pmod[k]));
                        if (mlq[i])        mlvl[k][i] = maxv[k];
                        else if (tick_now) mlvl[k][i] = (mlvl[k][i] - stepv[k] < 0) ? 0 : mlvl[k][i] - stepv[k];
                    end
                end
            end
            mcnt = enable ? mcnt + 1 : 0;
            mlq  = led_in;
        end
    end

    always @(negedge clk) begin
        chk("led_out4", 32'(led_out4), 32'(mout[0]));
        chk("active4",  32'(active4),  32'(mact[0]));
        chk("busy4",    32'(busy4),    32'(mbusy[0]));
        chk("led_out5", 32'(led_out5), 32'(mout[1]));
        chk("active5",  32'(active5),  32'(mact[1]));
        chk("busy5",    32'(busy5),    32'(mbusy[1]));
        for (int i = 0; i < 14; i++) begin
            chk("level4", 32'(u_dut.level_q[i]),  mlvl[0][i]);
            chk("level5", 32'(u_dut5.level_q[i]), mlvl[1][i]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int prev4, cur4, prev5, cur5, n_dec, last_c, seen3, found, lvl_or;

    initial begin
        // Reset with all inputs held high.
        step(3);
        chk("rst_led_out", 32'(led_out4), 0);
        chk("rst_busy", 32'(busy4), 0);
        reset_n = 1'b1;
        step(1);
        chk("post_rst_e1_out", 32'(led_out4), 0);
        step(1);
        chk("post_rst_e2_out", 32'(led_out4), 32'h3FFF);
        chk("post_rst_e2_act", 32'(active4), 0);
        step(1);
        chk("post_rst_e3_act", 32'(active4), 32'h3FFF);
        chk("post_rst_e3_out5", 32'(led_out5), 32'h3FFF);

        led_in = '0;
        step(300);
        chk("faded_busy4", 32'(busy4), 0);
        chk("faded_busy5", 32'(busy5), 0);

        // Single-LED pulse and full fade.
        led_in = 14'h0001;
        step(10);
        chk("pulse_lvl255", 32'(u_dut.level_q[0]), 255);
        led_in = '0;
        prev4 = 255; prev5 = 63; n_dec = 0; last_c = 0; seen3 = 0;
        for (int c = 1; c <= 300; c++) begin
            step(1);
            cur4 = int'(u_dut.level_q[0]);
            cur5 = int'(u_dut5.level_q[0]);
            if (cur4 != prev4) begin
                n_dec++;
                if (n_dec == 1) chk("first_dec", cur4, 251);
                else            chk("dec_spacing", c - last_c, 4);
                chk("dec_amount", cur4, (prev4 > 4) ? prev4 - 4 : 0);
                last_c = c;
            end
            if (cur5 != prev5 && prev5 == 3) begin
                seen3 = 1;
                chk("sat5_to_zero", cur5, 0);
            end
            prev4 = cur4;
            prev5 = cur5;
        end
        chk("n_dec4", n_dec, 64);
        chk("seen_level3", seen3, 1);
        chk("pulse_end_active", 32'(active4[0]), 0);

        // Re-trigger coincident with a decay tick.
        led_in = 14'h0020;
        step(5);
        led_in = '0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            step(1);
            if (u_dut.level_q[5] == 8'd127) found = 1;
        end
        chk("found127", found, 1);
        if (found == 1) begin
            step(2);
            led_in = 14'h0020;
            step(1);
            chk("retrig_hold127", 32'(u_dut.level_q[5]), 127);
            led_in = '0;
            step(1);
            chk("retrig_max", 32'(u_dut.level_q[5]), 255);
        end

        // One-cycle blank during fades.
        led_in = 14'h000F;
        step(6);
        led_in = '0;
        step(20);
        enable = 1'b0;
        step(1);
        chk("blank_out", 32'(led_out4), 0);
        lvl_or = 0;
        for (int i = 0; i < 4; i++) lvl_or |= int'(u_dut.level_q[i]);
        chk("blank_levels", lvl_or, 0);
        chk("blank_presc", 32'(u_dut.presc_cnt_q), 0);
        enable = 1'b1;
        step(1);
        chk("blank_busy", 32'(busy4), 0);
        chk("restart_pwm", 32'(u_dut.pwm_cnt_q), 1);
        chk("restart_tick_e1", 32'(u_dut.tick_q), 0);
        step(1);
        chk("restart_tick_e2", 32'(u_dut.tick_q), 0);
        step(1);
        chk("restart_tick_e3", 32'(u_dut.tick_q), 0);
        step(1);
        chk("restart_tick_e4", 32'(u_dut.tick_q), 1);

        // Asynchronous reset mid-fade.
        led_in = 14'h0080;
        step(5);
        led_in = '0;
        step(12);
        chk("pre_rst_busy", 32'(busy4), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_out", 32'(led_out4), 0);
        chk("async_active", 32'(active4), 0);
        chk("async_busy", 32'(busy4), 0);
        step(2);
        reset_n = 1'b1;
        step(30);
        chk("post_async_busy4", 32'(busy4), 0);
        chk("post_async_busy5", 32'(busy5), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
